// File: rtl/patch_injector.sv
// Patch injector: substitutes streamed patch words onto RAM DQ during read bursts.
// Optional PATCH_INJECTOR_COUNT_EN enables the saturating patched-burst counter.
module patch_injector #(
  parameter int MAX_WORDS   = 16,
  parameter int ARM_TIMEOUT = 32
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic        burst_addr_strobe,
  input  logic        burst_is_read,
  input  logic        burst_end,
  input  logic        ram_word_strobe,
  input  logic        patch_trigger,
  input  logic [15:0] patch_data,
  output logic        patch_data_next,
  output logic [15:0] ram_dq_out,
  output logic        ram_dq_oe,
  output logic        patch_active,
  output logic [15:0] patch_count
);

  localparam int CW = $clog2(MAX_WORDS) + 1;
  localparam int TW = $clog2(ARM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_DRIVE,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        read_q, read_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0] dq_q, dq_d;
  logic        oe_q, oe_d;
  logic        active_q, active_d;
  logic        next_d;

  always_comb begin
    state_d = state_q;
    read_d  = burst_addr_strobe ? burst_is_read : read_q;
    wcnt_d  = wcnt_q;
    tmo_d   = tmo_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    next_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (patch_trigger && read_q)
          state_d = S_ARMED;
      end
      S_ARMED: begin
        if (burst_end) begin
          state_d = S_IDLE;
        end else if (ram_word_strobe) begin
          state_d = S_DRIVE;
          dq_d    = patch_data;
          oe_d    = 1'b1;
          next_d  = 1'b1;
          wcnt_d  = CW'(1);
        end else if (tmo_q == TW'(ARM_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRIVE: begin
        if (burst_end) begin
          state_d = S_IDLE;
          oe_d    = 1'b0;
          wcnt_d  = '0;
        end else if (ram_word_strobe) begin
          if (wcnt_q == CW'(MAX_WORDS)) begin
            state_d = S_DONE;
            oe_d    = 1'b0;
          end else begin
            dq_d   = patch_data;
            next_d = 1'b1;
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        if (burst_end) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A new address while busy means the burst_end was missed.
    if (burst_addr_strobe && state_q != S_IDLE) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      dq_d    = dq_q;
      next_d  = 1'b0;
      wcnt_d  = '0;
      tmo_d   = '0;
    end
    active_d = (state_d == S_ARMED) || (state_d == S_DRIVE);
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      read_q   <= 1'b0;
      wcnt_q   <= '0;
      tmo_q    <= '0;
      dq_q     <= '0;
      oe_q     <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      read_q   <= read_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      dq_q     <= dq_d;
      oe_q     <= oe_d;
      active_q <= active_d;
    end
  end

  assign patch_data_next = next_d;
  assign ram_dq_out      = dq_q;
  assign ram_dq_oe       = oe_q;
  assign patch_active    = active_q;

`ifdef PATCH_INJECTOR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ARMED && state_d == S_DRIVE && cnt_q != 16'hFFFF)
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign patch_count = cnt_q;
`else
  assign patch_count = '0;
`endif

endmodule

// File: tb/tb_patch_injector.sv
// Bench for patch_injector: directed scenarios plus random bursts
// checked cycle by cycle against a behavioural model.
module tb_patch_injector;

  localparam int MAXW = 16;
  localparam int TMO  = 32;

  logic        mclk = 1'b0;
  logic        reset;
  logic        bas, rd, be, ws, trig;
  logic [15:0] pd;
  logic        pdn;
  logic [15:0] dq;
  logic        oe;
  logic        active;
  logic [15:0] pcount;

  patch_injector #(.MAX_WORDS(MAXW), .ARM_TIMEOUT(TMO)) dut (
    .mclk              (mclk),
    .reset             (reset),
    .burst_addr_strobe (bas),
    .burst_is_read     (rd),
    .burst_end         (be),
    .ram_word_strobe   (ws),
    .patch_trigger     (trig),
    .patch_data        (pd),
    .patch_data_next   (pdn),
    .ram_dq_out        (dq),
    .ram_dq_oe         (oe),
    .patch_active      (active),
    .patch_count       (pcount)
  );

  always #5 mclk = ~mclk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // patch store stand-in
  logic [15:0] tbl [0:31];
  int  pidx;
  bit  fixed_words;

  // behavioural model: what the bus should show, by rule
  localparam int M_IDLE = 0, M_WAIT = 1, M_PATCH = 2, M_SPENT = 3;
  int          m_mode;
  bit          m_read;
  int          m_words;
  int          m_age;
  logic [15:0] m_out;
  bit          m_oe;
  int          m_cnt;
  int          npulse;

  task automatic model_reset();
    m_mode = M_IDLE; m_read = 0; m_words = 0; m_age = 0;
    m_out = 16'h0; m_oe = 0; m_cnt = 0;
  endtask

  function automatic bit exp_next(bit b, bit e, bit w);
    bit ok;
    ok = (m_mode == M_WAIT) || (m_mode == M_PATCH && m_words < MAXW);
    return ok && w && !e && !b;
  endfunction

  task automatic model_step(bit b, bit r, bit e, bit w, bit t,
                            logic [15:0] d);
    bit was_read;
    was_read = m_read;
    if (b) m_read = r;
    if (b && m_mode != M_IDLE) begin
      m_mode = M_IDLE; m_oe = 0; m_words = 0;
      return;
    end
    case (m_mode)
      M_IDLE: if (t && was_read) begin m_mode = M_WAIT; m_age = 0; end
      M_WAIT: begin
        if (e) m_mode = M_IDLE;
        else if (w) begin
          m_mode = M_PATCH; m_out = d; m_oe = 1; m_words = 1;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_age++;
          if (m_age >= TMO) m_mode = M_IDLE;
        end
      end
      M_PATCH: begin
        if (e) begin m_mode = M_IDLE; m_oe = 0; m_words = 0; end
        else if (w) begin
          if (m_words >= MAXW) begin m_mode = M_SPENT; m_oe = 0; end
          else begin m_out = d; m_words++; end
        end
      end
      default: if (e) begin m_mode = M_IDLE; m_words = 0; end
    endcase
  endtask

  function automatic logic [15:0] exp_count();
`ifdef PATCH_INJECTOR_COUNT_EN
    return 16'(m_cnt);
`else
    return 16'h0;
`endif
  endfunction

  task automatic check_regs();
    chk("oe", {31'b0, oe}, {31'b0, m_oe});
    chk("dq", {16'b0, dq}, {16'b0, m_out});
    chk("active", {31'b0, active},
        {31'b0, (m_mode == M_WAIT || m_mode == M_PATCH)});
    chk("count", {16'b0, pcount}, {16'b0, exp_count()});
  endtask

  // one mclk cycle with the given inputs
  task automatic cyc(bit b, bit r, bit e, bit w, bit t);
    bit got;
    @(negedge mclk);
    check_regs();
    bas = b; rd = r; be = e; ws = w; trig = t;
    pd = tbl[pidx % 32];
    #1;
    got = pdn;
    chk("pdn", {31'b0, got}, {31'b0, exp_next(b, e, w)});
    if (got) npulse++;
    model_step(b, r, e, w, t, pd);
    @(posedge mclk);
    if (got) pidx++;
    if (t) begin
      pidx = 0;
      for (int i = 0; i < 32; i++)
        tbl[i] = fixed_words ? 16'((i + 1) * 16'h1111) : 16'($urandom);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic start_read();
    cyc(1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1; bas = 0; rd = 0; be = 0; ws = 0; trig = 0; pd = 0;
    pidx = 0; fixed_words = 1; npulse = 0;
    for (int i = 0; i < 32; i++) tbl[i] = 16'h0;
    model_reset();
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    chk("rst_oe", {31'b0, oe}, 32'd0);
    chk("rst_dq", {16'b0, dq}, 32'd0);
    chk("rst_active", {31'b0, active}, 32'd0);
    chk("rst_count", {16'b0, pcount}, 32'd0);
    chk("rst_pdn", {31'b0, pdn}, 32'd0);
    reset = 0;

    // four patched words 1111..4444
    npulse = 0;
    start_read();
    idle(1);
    repeat (4) cyc(0, 0, 0, 1, 0);
    idle(1);
    chk("t1_last", {16'b0, dq}, 32'h4444);
    cyc(0, 0, 1, 0, 0);
    idle(2);
    chk("t1_pulses", npulse, 4);
    fixed_words = 0;

    // trigger on a write burst is ignored
    npulse = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    chk("t2_pulses", npulse, 0);

    // word limit: 20 strobes, 16 consumed
    npulse = 0;
    start_read();
    repeat (20) cyc(0, 0, 0, 1, 0);
    idle(1);
    chk("t3_oe", {31'b0, oe}, 32'd0);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    chk("t3_pulses", npulse, MAXW);

    // arm timeout, late strobe ignored
    npulse = 0;
    start_read();
    idle(TMO + 4);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    idle(1);
    chk("t4_pulses", npulse, 0);
    chk("t4_active", {31'b0, active}, 32'd0);

    // burst_end with the third strobe
    npulse = 0;
    start_read();
    repeat (2) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    idle(1);
    chk("t5_pulses", npulse, 2);

    // async reset mid-drive
    start_read();
    repeat (3) cyc(0, 0, 0, 1, 0);
    @(negedge mclk);
    chk("t6_pre_oe", {31'b0, oe}, 32'd1);
    bas = 0; be = 0; ws = 1; trig = 0;
    #2 reset = 1;
    #1;
    chk("t6_oe", {31'b0, oe}, 32'd0);
    chk("t6_dq", {16'b0, dq}, 32'd0);
    chk("t6_active", {31'b0, active}, 32'd0);
    chk("t6_pdn", {31'b0, pdn}, 32'd0);
    chk("t6_count", {16'b0, pcount}, 32'd0);
    ws = 0;
    model_reset();
    @(posedge mclk);
    @(negedge mclk);
    reset = 0;

    // three patched reads and one timed-out arm
    for (int k = 0; k < 3; k++) begin
      start_read();
      repeat (2) cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 1, 0, 0);
    end
    start_read();
    idle(TMO + 2);
    @(negedge mclk);
`ifdef PATCH_INJECTOR_COUNT_EN
    chk("t7_count", {16'b0, pcount}, 32'd3);
`else
    chk("t7_count", {16'b0, pcount}, 32'd0);
`endif

    // random bursts
    for (int n = 0; n < 60; n++) begin
      int len;
      bit rdb;
      idle($urandom_range(0, 3));
      rdb = ($urandom_range(0, 4) != 0);
      cyc(1, rdb, 0, 0, 0);
      cyc(0, 0, 0, 0, ($urandom_range(0, 4) != 0));
      if ($urandom_range(0, 9) == 0) idle(TMO - 2 + $urandom_range(0, 4));
      len = $urandom_range(1, 24);
      for (int i = 0; i < len; i++)
        cyc(0, 0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 6), 0);
      if ($urandom_range(0, 9) != 0)
        cyc(0, 0, 1, ($urandom_range(0, 3) == 0), 0);
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/patch_injector.md
Name: patch_injector

Overview:
Consumer side of the patch data interface. Takes the patch trigger and streaming patch words from the patch store and substitutes them onto the RAM data bus during read bursts, pulsing patch_data_next once per word consumed. Sits between the RAM burst tracker (burst strobes, per-word timing) and the FPGA's RAM DQ output drivers.

Parameters:
MAX_WORDS, 16, maximum words driven per patched burst; further words in the same burst pass through unpatched.
ARM_TIMEOUT, 32, mclk cycles allowed in ARMED without a word strobe before abandoning the patch.

Ports:
mclk  input  1  system clock; all logic rising-edge.
reset  input  1  asynchronous, active-high.
burst_addr_strobe  input  1  one-cycle pulse; new burst address valid (same pulse the patch store sees).
burst_is_read  input  1  qualifies burst_addr_strobe; 1 = read burst.
burst_end  input  1  one-cycle pulse; current burst finished.
ram_word_strobe  input  1  one-cycle pulse; next RAM data word is due on the bus in the following cycle.
patch_trigger  input  1  from patch store; arrives exactly 1 cycle after burst_addr_strobe.
patch_data  input  16  current patch word from patch store; valid whenever the injector is ARMED or DRIVE.
patch_data_next  output  1  one-cycle pulse; advance patch store to the next word.
ram_dq_out  output  16  registered data to drive on RAM DQ.
ram_dq_oe  output  1  registered output enable for ram_dq_out.
patch_active  output  1  high in ARMED or DRIVE.
patch_count  output  16  patched-burst counter (see Optional Feature).

Behaviour:
- Reset (async): state IDLE; ram_dq_out=0, ram_dq_oe=0, patch_data_next=0, patch_active=0, patch_count=0, word counter=0, read flag=0. Reset mid-burst drops ram_dq_oe immediately.
- Read flag: registered from burst_is_read on every burst_addr_strobe.
- States: IDLE, ARMED, DRIVE, DONE.
- IDLE -> ARMED: patch_trigger=1 and read flag=1 (i.e. the cycle after a read burst_addr_strobe). patch_trigger on a write burst is ignored; the state stays IDLE.
- ARMED: timeout counter increments every cycle. On ram_word_strobe: go to DRIVE, ram_dq_out<=patch_data, ram_dq_oe<=1, patch_data_next=1 (combinational, same cycle), word counter<=1. Timeout reaching ARM_TIMEOUT with no strobe: go to IDLE, no words consumed. burst_end in ARMED: go to IDLE.
- DRIVE: each ram_word_strobe latches patch_data into ram_dq_out, pulses patch_data_next and increments the word counter. Back-to-back strobes on consecutive cycles are legal; patch_data is valid one cycle after each patch_data_next. On a cycle without a strobe, ram_dq_oe holds its value and ram_dq_out holds the last word.
- Word limit: a strobe arriving when word counter==MAX_WORDS goes to DONE. ram_dq_oe<=0 and no patch_data_next pulse is issued.
- DONE: ignores strobes and drives nothing; waits for burst_end.
- burst_end in DRIVE or DONE: go to IDLE, ram_dq_oe<=0, word counter<=0.
- Simultaneous burst_end and ram_word_strobe: burst_end wins. No word is latched, no patch_data_next, ram_dq_oe<=0.
- burst_addr_strobe in any non-IDLE state (missed burst_end): abort to IDLE at once and drop ram_dq_oe. The following cycle's patch_trigger is evaluated normally from IDLE.
- patch_data_next is never asserted outside ARMED or DRIVE.
- patch_active is registered: high exactly while the state is ARMED or DRIVE.
- Word counter is $clog2(MAX_WORDS)+1 bits and never wraps.

Optional Feature:
PATCH_INJECTOR_COUNT_EN.
- Defined: patch_count increments by 1 on each ARMED->DRIVE transition and saturates at 16'hFFFF. Reset clears it.
- Undefined: patch_count is tied to 0 and the counter logic is not synthesised.

Test Plan:
- Read burst at t, trigger at t+1, 4 word strobes at t+3..t+6 with patch_data 16'h1111..16'h4444 -> ram_dq_out 1111..4444 at t+4..t+7, oe=1, 4 patch_data_next pulses, burst_end -> oe=0 next cycle, state IDLE.
- Write burst with patch_trigger=1 -> no oe, no patch_data_next, patch_active stays 0.
- MAX_WORDS=16, 20 strobes -> exactly 16 patch_data_next pulses; oe drops on the 17th strobe; words 17..20 not driven; IDLE after burst_end.
- Trigger, then no strobe for 32 cycles -> return to IDLE at cycle 32 with zero patch_data_next; a later strobe has no effect.
- burst_end coincident with the 3rd strobe -> only 2 pulses, oe=0 next cycle. Async reset asserted mid-DRIVE -> oe=0 immediately, all outputs at reset values.
- With PATCH_INJECTOR_COUNT_EN, 3 patched reads plus 1 timed-out arm -> patch_count=3. Without the macro, patch_count=0 throughout.
